// File: rtl/mem_lsu_if.sv
// Data-memory request/acknowledge bus between the load/store unit and memory.
// The master drives the request fields; the slave returns read data and ack.
interface mem_lsu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        sel;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;

    modport master (
        output req, we, addr, sel, wdata,
        input  rdata, ack
    );

    modport slave (
        input  req, we, addr, sel, wdata,
        output rdata, ack
    );
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: big-endian byte lanes, one bus access per op,
// and a stall held until the access has completed.
module mem_lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        mem_waddr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_wreg,
    input  logic              mem_whilo,
    input  logic [DATA_W-1:0] mem_hi,
    input  logic [DATA_W-1:0] mem_lo,
    input  logic [3:0]        mem_op,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_sdata,
    mem_lsu_if.master         bus,
    output logic [4:0]        wb_waddr,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              wb_wreg,
    output logic              wb_whilo,
    output logic [DATA_W-1:0] wb_hi,
    output logic [DATA_W-1:0] wb_lo,
    output logic              stallreq,
    output logic              exc_adel,
    output logic              exc_ades
);
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_sel;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata_q;

    logic              w_load;
    logic              w_store;
    logic              w_byte;
    logic              w_half;
    logic              w_word;
    logic              w_misal;
    logic              w_access;
    logic [3:0]        w_sel;
    logic [DATA_W-1:0] w_wdata;
    logic [7:0]        w_lbyte;
    logic [15:0]       w_lhalf;
    logic [DATA_W-1:0] w_ldata;

    assign w_load  = (mem_op >= OP_LB) && (mem_op <= OP_LW);
    assign w_store = (mem_op >= OP_SB) && (mem_op <= OP_SW);
    assign w_byte  = (mem_op == OP_LB) || (mem_op == OP_LBU) ||
                     (mem_op == OP_SB);
    assign w_half  = (mem_op == OP_LH) || (mem_op == OP_LHU) ||
                     (mem_op == OP_SH);
    assign w_word  = (mem_op == OP_LW) || (mem_op == OP_SW);

    assign w_misal  = (w_half && mem_addr[0]) ||
                      (w_word && (mem_addr[1:0] != 2'b00));
    assign w_access = (w_load || w_store) && !w_misal;

    // Byte k of the word lives on lane 3-k (big-endian).
    always_comb begin
        w_sel   = 4'b1111;
        w_wdata = mem_sdata;
        unique case (1'b1)
            w_byte: begin
                w_sel   = 4'b1000 >> mem_addr[1:0];
                w_wdata = {4{mem_sdata[7:0]}};
            end
            w_half: begin
                w_sel   = mem_addr[1] ? 4'b0011 : 4'b1100;
                w_wdata = {2{mem_sdata[15:0]}};
            end
            default: begin
                w_sel   = 4'b1111;
                w_wdata = mem_sdata;
            end
        endcase
    end

    always_comb begin
        w_lbyte = r_rdata_q[8*(3-mem_addr[1:0]) +: 8];
        w_lhalf = mem_addr[1] ? r_rdata_q[15:0] : r_rdata_q[31:16];
        w_ldata = r_rdata_q;
        unique case (mem_op)
            OP_LB:   w_ldata = {{24{w_lbyte[7]}}, w_lbyte};
            OP_LBU:  w_ldata = {24'd0, w_lbyte};
            OP_LH:   w_ldata = {{16{w_lhalf[15]}}, w_lhalf};
            OP_LHU:  w_ldata = {16'd0, w_lhalf};
            default: w_ldata = r_rdata_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_access) w_next = S_BUSY;
            S_BUSY:  if (bus.ack) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_sel     <= 4'b0000;
            r_wdata   <= '0;
            r_rdata_q <= '0;
        end else if (r_state == S_IDLE && w_access) begin
            r_req   <= 1'b1;
            r_we    <= w_store;
            r_addr  <= {mem_addr[ADDR_W-1:2], 2'b00};
            r_sel   <= w_sel;
            r_wdata <= w_wdata;
        end else if (r_state == S_BUSY && bus.ack) begin
            r_req     <= 1'b0;
            r_rdata_q <= bus.rdata;
        end
    end

    assign bus.req   = r_req;
    assign bus.we    = r_we;
    assign bus.addr  = r_addr;
    assign bus.sel   = r_sel;
    assign bus.wdata = r_wdata;

    always_comb begin
        wb_waddr = mem_waddr;
        wb_wdata = mem_wdata;
        wb_wreg  = mem_wreg;
        wb_whilo = mem_whilo;
        wb_hi    = mem_hi;
        wb_lo    = mem_lo;
        stallreq = 1'b0;
        exc_adel = 1'b0;
        exc_ades = 1'b0;
        if (!rst) begin
            wb_waddr = '0;
            wb_wdata = '0;
            wb_wreg  = 1'b0;
            wb_whilo = 1'b0;
            wb_hi    = '0;
            wb_lo    = '0;
        end else if (w_misal) begin
            exc_adel = w_load;
            exc_ades = w_store;
            wb_wreg  = 1'b0;
        end else if (w_access) begin
            // The write-back is only valid once the access has completed.
            if (r_state == S_DONE) begin
                wb_wdata = w_load ? w_ldata : mem_wdata;
                wb_wreg  = w_load ? mem_wreg : 1'b0;
            end else begin
                wb_wreg  = 1'b0;
                stallreq = 1'b1;
            end
        end
    end
endmodule
